// File: rtl/dc_chain_param_if.sv
// Two-lane sample-pair stream into and out of the delay-commutator chain.
interface dc_chain_param_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] x0;
  logic [DATA_WIDTH-1:0] x1;
  logic [DATA_WIDTH-1:0] y0;
  logic [DATA_WIDTH-1:0] y1;
  logic                  out_valid;
  logic                  out_sof;

  modport master (output in_valid, x0, x1, input  y0, y1, out_valid, out_sof);
  modport slave  (input  in_valid, x0, x1, output y0, y1, out_valid, out_sof);
endinterface

// File: rtl/dc_chain_param.sv
// Parametrised two-lane delay-commutator chain; state advances only on valid beats.
// Fixed latency of 2^S-1 beats; out_sof marks the first pair of each 2^S-pair frame.
module dc_chain_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DESCENDING = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  dc_chain_param_if.slave  bus
);
  localparam int unsigned S = NUM_STAGES;
  localparam int unsigned F = 1 << S;
  localparam int unsigned L = F - 1;

  logic                       w_beat;
  logic                       w_filled;
  logic [S-1:0]               r_fill;
  logic [S-1:0]               r_out_cnt;
  logic [S:0][DATA_WIDTH-1:0] w_l0;
  logic [S:0][DATA_WIDTH-1:0] w_l1;

  assign w_beat   = bus.in_valid;
  assign w_filled = (r_fill == S'(L));
  assign w_l0[0]  = bus.x0;
  assign w_l1[0]  = bus.x1;

  // Beats accepted since reset, saturating at the chain latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fill <= '0;
    end else if (w_beat && !w_filled) begin
      r_fill <= r_fill + S'(1);
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int unsigned DLOG = (DESCENDING != 0) ? (S - 1 - k) : k;
    localparam int unsigned D    = 1 << DLOG;
    localparam int unsigned UP   = (DESCENDING != 0) ? (F - (F >> k)) : ((1 << k) - 1);
    localparam int unsigned CW   = DLOG + 1;

    logic                       w_en;
    logic                       w_cross;
    logic [CW-1:0]              r_cnt;
    logic [D-1:0][DATA_WIDTH-1:0] r_a;
    logic [D-1:0][DATA_WIDTH-1:0] r_u;
    logic [DATA_WIDTH-1:0]      w_a;
    logic [DATA_WIDTH-1:0]      w_u;
    logic [DATA_WIDTH-1:0]      w_v;

    // Counter phase starts with the first beat whose data has reached this stage.
    if (UP == 0) begin : g_first
      assign w_en = w_beat;
    end else begin : g_later
      assign w_en = w_beat && (r_fill >= S'(UP));
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (w_en) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign w_cross = r_cnt[CW-1];
    assign w_a     = r_a[D-1];
    assign w_u     = w_cross ? w_a : w_l0[k];
    assign w_v     = w_cross ? w_l0[k] : w_a;

    // Lane-1 pre-delay and post-switch lane-0 delay, both D beats deep.
    if (D == 1) begin : g_d1
      always_ff @(posedge clk) begin
        if (reset_n && w_beat) begin
          r_a <= w_l1[k];
          r_u <= w_u;
        end
      end
    end else begin : g_dn
      always_ff @(posedge clk) begin
        if (reset_n && w_beat) begin
          r_a <= {r_a[D-2:0], w_l1[k]};
          r_u <= {r_u[D-2:0], w_u};
        end
      end
    end

    assign w_l0[k+1] = r_u[D-1];
    assign w_l1[k+1] = w_v;
  end

  // Registered output; y0/y1 hold across idle and fill cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.y0        <= '0;
      bus.y1        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      r_out_cnt     <= '0;
    end else begin
      bus.out_valid <= w_beat && w_filled;
      bus.out_sof   <= w_beat && w_filled && (r_out_cnt == '0);
      if (w_beat && w_filled) begin
        bus.y0    <= w_l0[S];
        bus.y1    <= w_l1[S];
        r_out_cnt <= r_out_cnt + S'(1);
      end
    end
  end
endmodule

// File: tb/tb_dc_chain_param.sv
// Directed bench for dc_chain_param: S=1, S=2, S=4 (both orders) and S=6 instances
// share one stimulus stream; S=4/S=6 are checked against a closed-form reorder model.
`timescale 1ns/1ps
module tb_dc_chain_param;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          r_v;
  logic [DW-1:0] r_x0;
  logic [DW-1:0] r_x1;
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] hist0 [256];
  logic [DW-1:0] hist1 [256];
  int            e2_y0 [8] = '{0, 2, 100, 102, 4, 6, 104, 106};
  int            e2_sof[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  int            e1_y0 [4] = '{0, 100, 2, 102};
  int            e1_sof[4] = '{1, 0, 1, 0};

  always #5 clk = ~clk;

  dc_chain_param_if #(.DATA_WIDTH(DW)) if_s1 ();
  dc_chain_param_if #(.DATA_WIDTH(DW)) if_s2 ();
  dc_chain_param_if #(.DATA_WIDTH(DW)) if_s4d ();
  dc_chain_param_if #(.DATA_WIDTH(DW)) if_s4a ();
  dc_chain_param_if #(.DATA_WIDTH(DW)) if_s6 ();

  assign if_s1.in_valid  = r_v;  assign if_s1.x0  = r_x0; assign if_s1.x1  = r_x1;
  assign if_s2.in_valid  = r_v;  assign if_s2.x0  = r_x0; assign if_s2.x1  = r_x1;
  assign if_s4d.in_valid = r_v;  assign if_s4d.x0 = r_x0; assign if_s4d.x1 = r_x1;
  assign if_s4a.in_valid = r_v;  assign if_s4a.x0 = r_x0; assign if_s4a.x1 = r_x1;
  assign if_s6.in_valid  = r_v;  assign if_s6.x0  = r_x0; assign if_s6.x1  = r_x1;

  dc_chain_param #(.DATA_WIDTH(DW), .NUM_STAGES(1), .DESCENDING(1))
    u_s1  (.clk(clk), .reset_n(reset_n), .bus(if_s1));
  dc_chain_param #(.DATA_WIDTH(DW), .NUM_STAGES(2), .DESCENDING(1))
    u_s2  (.clk(clk), .reset_n(reset_n), .bus(if_s2));
  dc_chain_param #(.DATA_WIDTH(DW), .NUM_STAGES(4), .DESCENDING(1))
    u_s4d (.clk(clk), .reset_n(reset_n), .bus(if_s4d));
  dc_chain_param #(.DATA_WIDTH(DW), .NUM_STAGES(4), .DESCENDING(0))
    u_s4a (.clk(clk), .reset_n(reset_n), .bus(if_s4a));
  dc_chain_param #(.DATA_WIDTH(DW), .NUM_STAGES(6), .DESCENDING(1))
    u_s6  (.clk(clk), .reset_n(reset_n), .bus(if_s6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
    r_v  = v;
    r_x0 = a;
    r_x1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    reset_n = 1'b1;
  endtask

  // S=2 descending on x0=t, x1=100+t; optional ~40% idle cycles, optional S=1 check.
  task automatic run_s2(input bit stall, input bit with_s1);
    int t;
    int guard;
    int e0;
    logic [DW-1:0] h0;
    logic [DW-1:0] h1;
    t = 0;
    guard = 0;
    h0 = '0;
    h1 = '0;
    while (t <= 10 && guard < 400) begin
      guard++;
      if (stall && $urandom_range(0, 99) < 40) begin
        tick(1'b0, DW'(16'hdead), DW'(16'hbeef));
        chk("s2_idle_valid", 32'(if_s2.out_valid), 32'd0);
        chk("s2_idle_sof",   32'(if_s2.out_sof),   32'd0);
        chk("s2_idle_y0",    32'(if_s2.y0),        32'(h0));
        chk("s2_idle_y1",    32'(if_s2.y1),        32'(h1));
      end else begin
        tick(1'b1, DW'(t), DW'(100 + t));
        if (t < 3) begin
          chk("s2_fill_valid", 32'(if_s2.out_valid), 32'd0);
          chk("s2_fill_y0",    32'(if_s2.y0),        32'd0);
        end else begin
          e0 = e2_y0[t-3];
          h0 = DW'(e0);
          h1 = DW'(e0 + 1);
          chk("s2_valid", 32'(if_s2.out_valid), 32'd1);
          chk("s2_y0",    32'(if_s2.y0),        32'(h0));
          chk("s2_y1",    32'(if_s2.y1),        32'(h1));
          chk("s2_sof",   32'(if_s2.out_sof),   32'(e2_sof[t-3]));
        end
        if (with_s1 && t == 0) begin
          chk("s1_fill_valid", 32'(if_s1.out_valid), 32'd0);
        end else if (with_s1 && t <= 4) begin
          chk("s1_valid", 32'(if_s1.out_valid), 32'd1);
          chk("s1_y0",    32'(if_s1.y0),        32'(e1_y0[t-1]));
          chk("s1_y1",    32'(if_s1.y1),        32'(e1_y0[t-1] + 1));
          chk("s1_sof",   32'(if_s1.out_sof),   32'(e1_sof[t-1]));
        end
        t++;
      end
    end
    chk("s2_done", 32'(t), 32'd11);
  endtask

  // Output (beat n, lane l): descending takes lane t[S-1], beat {t[S-2:0],l};
  // ascending takes lane t[0], beat {l,t[S-1:1]}, all within frame n/F.
  task automatic chk_inst(input string tag, input int s, input bit desc, input int b,
                          input logic v, input logic sof,
                          input logic [DW-1:0] y0, input logic [DW-1:0] y1);
    int f;
    int lat;
    int n;
    int m;
    int t;
    int lane_in;
    int beat_in;
    logic [DW-1:0] ev [2];
    f   = 1 << s;
    lat = f - 1;
    if (b < lat) begin
      chk({tag, "_fill_valid"}, 32'(v),  32'd0);
      chk({tag, "_fill_y0"},    32'(y0), 32'd0);
    end else begin
      n = b - lat;
      m = n / f;
      t = n % f;
      for (int l = 0; l < 2; l++) begin
        if (desc) begin
          lane_in = (t >> (s - 1)) & 1;
          beat_in = ((t << 1) | l) & (f - 1);
        end else begin
          lane_in = t & 1;
          beat_in = (l << (s - 1)) | (t >> 1);
        end
        ev[l] = (lane_in != 0) ? hist1[m*f + beat_in] : hist0[m*f + beat_in];
      end
      chk({tag, "_valid"}, 32'(v),   32'd1);
      chk({tag, "_sof"},   32'(sof), 32'((t == 0) ? 1 : 0));
      chk({tag, "_y0"},    32'(y0),  32'(ev[0]));
      chk({tag, "_y1"},    32'(y1),  32'(ev[1]));
    end
  endtask

  task automatic run_model(input int nbeats, input bit ramp);
    for (int i = 0; i < nbeats; i++) begin
      hist0[i] = ramp ? DW'(i)        : DW'($urandom);
      hist1[i] = ramp ? DW'(1000 + i) : DW'($urandom);
      tick(1'b1, hist0[i], hist1[i]);
      chk_inst("s4d", 4, 1'b1, i, if_s4d.out_valid, if_s4d.out_sof, if_s4d.y0, if_s4d.y1);
      chk_inst("s4a", 4, 1'b0, i, if_s4a.out_valid, if_s4a.out_sof, if_s4a.y0, if_s4a.y1);
      chk_inst("s6",  6, 1'b1, i, if_s6.out_valid,  if_s6.out_sof,  if_s6.y0,  if_s6.y1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    r_v     = 1'b0;
    r_x0    = '0;
    r_x1    = '0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_s2_valid",  32'(if_s2.out_valid),  32'd0);
    chk("rst_s2_sof",    32'(if_s2.out_sof),    32'd0);
    chk("rst_s2_y0",     32'(if_s2.y0),         32'd0);
    chk("rst_s2_y1",     32'(if_s2.y1),         32'd0);
    chk("rst_s4d_valid", 32'(if_s4d.out_valid), 32'd0);
    chk("rst_s6_y1",     32'(if_s6.y1),         32'd0);

    // Transpose S=1 and S=2 descending, back-to-back beats.
    run_s2(1'b0, 1'b1);

    // Same vectors with random idle cycles.
    do_reset();
    run_s2(1'b1, 1'b0);

    // Reset at beat 9 coinciding with a valid beat, then restart.
    do_reset();
    for (int t = 0; t < 9; t++) tick(1'b1, DW'(t), DW'(100 + t));
    chk("pre_rst_s2_y0", 32'(if_s2.y0), 32'd6);
    reset_n = 1'b0;
    tick(1'b1, DW'(9), DW'(109));
    chk("midrst_s2_valid", 32'(if_s2.out_valid), 32'd0);
    chk("midrst_s2_sof",   32'(if_s2.out_sof),   32'd0);
    chk("midrst_s2_y0",    32'(if_s2.y0),        32'd0);
    chk("midrst_s2_y1",    32'(if_s2.y1),        32'd0);
    reset_n = 1'b1;
    run_s2(1'b0, 1'b0);

    // S=4 both orders: 5 frames of random data plus the 15-beat latency.
    do_reset();
    run_model(95, 1'b0);

    // S=6: 3 frames of ramp data plus the 63-beat latency.
    do_reset();
    run_model(255, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dc_chain_param.md
# dc_chain_param

Parametrised two-lane delay-commutator chain for the MDC FFT datapath. It reorders a stream of sample pairs between butterfly columns. It generalises the fixed 8/4/2/1 chain in four ways:
- configurable stage count and delay order;
- true valid-beat stalling, where idle cycles do not advance state;
- a frame-start marker;
- a fixed, documented latency.

It sits between the FFT input buffer and the radix-2 butterfly array, one instance per antenna stream.

## Interface
- DATA_WIDTH, 16: width of each lane sample (opaque bits, no arithmetic).
- NUM_STAGES, 4: number of commutator stages S, with 1 ≤ S ≤ 6. Frame length F = 2^S pairs.
- DESCENDING, 1: delay order. 1 gives per-stage delays 2^(S-1), …, 2, 1. 0 gives delays 1, 2, …, 2^(S-1).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  x0/x1 carry a beat this cycle.
- x0  in  DATA_WIDTH  lane-0 input sample.
- x1  in  DATA_WIDTH  lane-1 input sample.
- y0  out  DATA_WIDTH  lane-0 output sample, registered.
- y1  out  DATA_WIDTH  lane-1 output sample, registered.
- out_valid  out  1  y0/y1 carry a valid beat.
- out_sof  out  1  first output pair of an F-pair frame; qualified by out_valid.

## Operation
- Beat: a cycle with in_valid=1. All state advances only on beats. Non-beat cycles freeze every buffer and counter.
- Stage with delay D (applied per beat):
  - the stage counter c runs 0..2D-1, wrapping;
  - a = lane-1 input delayed D beats;
  - straight when c<D: u=x0, v=a;
  - cross when c≥D: u=a, v=x0;
  - stage output = (u delayed D beats, v).
- Stage latency is D beats. Chain latency is L = 2^S − 1 beats, identical for both orders.
- Stage k counter starts at 0 on the first beat for which that stage's input is valid. Equivalently, c = (global_beat − upstream latency) mod 2D.
- Global beat counter: counts accepted beats and saturates at L. Once it reaches L, the chain is "filled".
- Output beat n is the chain output for input beat n+L.
- out_sof = 1 when n mod F == 0.
- The stream is continuous; there is no end-of-frame flush. Draining requires extra beats (zeros are allowed).
- Delay storage: two D-word buffers per stage, either shift registers or circular RAM with a pointer mod D. The choice is free, but contents are unobservable until the chain is filled.
- in_valid may toggle arbitrarily. There is no back-pressure; the block always accepts.

## Timing
- Reset (reset_n=0 at a clock edge), taking effect that edge:
  - y0=0, y1=0, out_valid=0, out_sof=0;
  - all counters 0, fill count 0.
  - Buffer contents need not be cleared.
- Reset mid-stream discards all in-flight data. The first beat after reset_n returns high is global beat 0.
- reset_n=0 has priority over a simultaneous in_valid.
- Beat accepted at edge t while filled (fill count = L before the edge): y0/y1 and out_valid=1 appear after edge t, i.e. one cycle after input. This is a registered output.
- Beat accepted while not filled: the fill count increments and out_valid stays 0.
- Non-beat cycle: out_valid=0, out_sof=0. y0/y1 hold their last value.
- Fill-count saturation: no wrap. The filled state persists until reset.
- Counter wrap at 2D−1 → 0 occurs on the beat itself. There is no bubble at a frame boundary.
- Throughput: one pair per cycle sustained.

## Test plan
- Transpose, S=1, D=1:
  - Stimulus: beats (a0,b0), (a1,b1), (a2,b2), (a3,b3) with a=0..3 and b=100..103.
  - Required: after beat 1, (0,1) with out_sof=1; then (100,101) with out_sof=0; then (2,3) with out_sof=1.
- S=2, DESCENDING=1:
  - Stimulus: x0=t, x1=100+t for t=0..10, back-to-back.
  - Required: out_valid first rises the cycle after beat 3.
  - Outputs in order: (0,1) sof, (2,3), (100,101), (102,103), (4,5) sof, (6,7), (104,105), (106,107).
- Stall insensitivity:
  - Stimulus: repeat the S=2 vectors with in_valid low on random cycles (about 40%).
  - Required: identical output pair sequence and sof positions. out_valid=0 on every idle-cycle response. y0/y1 held during idles.
- Full default config, both orders (S=4, DESCENDING=1 and DESCENDING=0):
  - Stimulus: 5 frames of random data.
  - Required: matches the per-stage golden model. Latency is exactly 15 beats. out_sof every 16th output beat.
- Reset mid-operation:
  - Stimulus: reset_n=0 at beat 9 of S=2 streaming (including in the same cycle as in_valid=1); then restart the t=0.. vectors.
  - Required: outputs 0 and out_valid=0 after the reset edge. The output sequence restarts exactly as in the S=2 DESCENDING=1 scenario, with no stale data emitted.
- Boundary S=6:
  - Stimulus: 3 frames of ramp data.
  - Required: latency 63 beats. out_sof every 64 beats. No glitch at the counter wrap of the D=32 stage.
